hs_sync_aligner: RTL and testbench

HS_SYNC_ALIGNER -- requirements
Module: hs_sync_aligner

---
 rtl/hs_sync_aligner.sv | 138 +++++++++++++
 tb/tb_hs_sync_aligner.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_sync_aligner.sv
// HS receive aligner: hunts for the zero preamble and sync character in the byte stream,
// then emits bit-aligned payload bytes at the offset where sync was found.
module hs_sync_aligner #(
   parameter logic [7:0]  SYNC_CHAR   = 8'h1D,
   parameter int unsigned ZERO_MIN    = 8,
   parameter int unsigned TIMEOUT_CYC = 16,
   parameter bit          ERR_TOL     = 1'b1
) (
   input  logic       RxByteClkHS,
   input  logic       Rst,
   input  logic       Enable,
   input  logic [7:0] DataHS,
   output logic       RxSyncHS,
   output logic [2:0] RxSyncPosition,
   output logic [7:0] RxDataHS,
   output logic       RxValidHS,
   output logic       ErrSotHS,
   output logic       ErrSotSyncHS
);

   localparam logic [15:0] ZeroMask    = 16'((32'd1 << ZERO_MIN) - 32'd1);
   localparam int          ZeroLast    = 16 - int'(ZERO_MIN);
   localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {StIdle, StHuntZero, StHuntSync, StLocked} state_e;

   state_e      state_q;
   logic [7:0]  prev_q;
   logic [7:0]  cnt_q;
   logic [7:0]  data_q;
   logic [2:0]  pos_q;
   logic        sync_q;
   logic        valid_q;
   logic        err_sot_q;
   logic        err_sync_q;

   logic [15:0] win;
   logic        zero_found;
   logic        exact_any;
   logic        err_any;
   logic [2:0]  exact_pos;
   logic [2:0]  err_pos;
   logic [7:0]  cand;
   logic [7:0]  diff;

   assign win = {DataHS, prev_q};

   always_comb begin
      zero_found = 1'b0;
      for (int j = 0; j <= ZeroLast; j++) begin
         if (((win >> j) & ZeroMask) == 16'h0000) zero_found = 1'b1;
      end
   end

   // Scan from the top offset down so the lowest matching offset is the one that sticks.
   always_comb begin
      exact_any = 1'b0;
      err_any   = 1'b0;
      exact_pos = 3'd0;
      err_pos   = 3'd0;
      cand      = 8'h00;
      diff      = 8'h00;
      for (int k = 7; k >= 0; k--) begin
         cand = win[k +: 8];
         diff = cand ^ SYNC_CHAR;
         if (diff == 8'h00) begin
            exact_any = 1'b1;
            exact_pos = 3'(k);
         end
         if ((diff != 8'h00) && ((diff & (diff - 8'd1)) == 8'h00)) begin
            err_any = 1'b1;
            err_pos = 3'(k);
         end
      end
   end

   always_ff @(posedge RxByteClkHS or posedge Rst) begin
      if (Rst) begin
         state_q    <= StIdle;
         prev_q     <= 8'hFF;
         cnt_q      <= 8'h00;
         data_q     <= 8'h00;
         pos_q      <= 3'd0;
         sync_q     <= 1'b0;
         valid_q    <= 1'b0;
         err_sot_q  <= 1'b0;
         err_sync_q <= 1'b0;
      end else begin
         sync_q     <= 1'b0;
         valid_q    <= 1'b0;
         err_sot_q  <= 1'b0;
         err_sync_q <= 1'b0;
         if (!Enable) begin
            state_q <= StIdle;
            cnt_q   <= 8'h00;
         end else begin
            prev_q <= DataHS;
            unique case (state_q)
               StIdle: state_q <= StHuntZero;
               StHuntZero: begin
                  if (zero_found) begin
                     state_q <= StHuntSync;
                     cnt_q   <= 8'h00;
                  end
               end
               StHuntSync: begin
                  if (exact_any || (ERR_TOL && err_any)) begin
                     state_q   <= StLocked;
                     sync_q    <= 1'b1;
                     err_sot_q <= ~exact_any;
                     pos_q     <= exact_any ? exact_pos : err_pos;
                     cnt_q     <= 8'h00;
                  end else if (cnt_q == TimeoutLast) begin
                     state_q    <= StHuntZero;
                     err_sync_q <= 1'b1;
                     cnt_q      <= 8'h00;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
               StLocked: begin
                  data_q  <= win[pos_q +: 8];
                  valid_q <= 1'b1;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign RxSyncHS       = sync_q;
   assign RxSyncPosition = pos_q;
   assign RxDataHS       = data_q;
   assign RxValidHS      = valid_q;
   assign ErrSotHS       = err_sot_q;
   assign ErrSotSyncHS   = err_sync_q;

endmodule

// File: tb/tb_hs_sync_aligner.sv
// Bench for hs_sync_aligner: per-scenario tasks drive bytes and push expected events
// that negedge monitors pop as each DUT emits sync, data or timeout.
module tb_hs_sync_aligner;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, en2 = 1'b0;
   logic [7:0] data = 8'h00, data2 = 8'h00;

   logic       sync1, val1, esot1, esync1;
   logic [2:0] pos1;
   logic [7:0] rxd1;
   logic       sync2, val2, esot2, esync2;
   logic [2:0] pos2;
   logic [7:0] rxd2;

   typedef struct packed {
      logic [2:0] kind;
      logic [7:0] val;
   } ev_t;

   ev_t sb1[$];
   ev_t sb2[$];
   int  total = 0;
   int  bad = 0;

   always #5 clk = ~clk;

   hs_sync_aligner dut (
      .RxByteClkHS(clk), .Rst(rst), .Enable(en), .DataHS(data),
      .RxSyncHS(sync1), .RxSyncPosition(pos1), .RxDataHS(rxd1), .RxValidHS(val1),
      .ErrSotHS(esot1), .ErrSotSyncHS(esync1)
   );

   hs_sync_aligner #(.ERR_TOL(1'b0), .TIMEOUT_CYC(4)) dut2 (
      .RxByteClkHS(clk), .Rst(rst), .Enable(en2), .DataHS(data2),
      .RxSyncHS(sync2), .RxSyncPosition(pos2), .RxDataHS(rxd2), .RxValidHS(val2),
      .ErrSotHS(esot2), .ErrSotSyncHS(esync2)
   );

   function automatic ev_t ev_sync(input logic err, input logic [2:0] pos);
      return {3'b001, 4'h0, err, pos};
   endfunction
   function automatic ev_t ev_data(input logic [7:0] d);
      return {3'b010, d};
   endfunction
   function automatic ev_t ev_tmo();
      return {3'b100, 8'h00};
   endfunction

   always @(negedge clk) begin : mon1
      ev_t got, exp;
      if (sync1 || esot1 || val1 || esync1) begin
         got.kind = {esync1, val1, sync1 | esot1};
         got.val  = (sync1 | esot1) ? {4'h0, esot1, pos1} : (val1 ? rxd1 : 8'h00);
         total++;
         if (sb1.size() == 0) begin
            bad++;
            $display("FAIL sb1_unexpected got kind=%b val=%02h want none", got.kind, got.val);
         end else begin
            exp = sb1.pop_front();
            if (got !== exp) begin
               bad++;
               $display("FAIL sb1_event got kind=%b val=%02h want kind=%b val=%02h",
                        got.kind, got.val, exp.kind, exp.val);
            end
         end
      end
   end

   always @(negedge clk) begin : mon2
      ev_t got, exp;
      if (sync2 || esot2 || val2 || esync2) begin
         got.kind = {esync2, val2, sync2 | esot2};
         got.val  = (sync2 | esot2) ? {4'h0, esot2, pos2} : (val2 ? rxd2 : 8'h00);
         total++;
         if (sb2.size() == 0) begin
            bad++;
            $display("FAIL sb2_unexpected got kind=%b val=%02h want none", got.kind, got.val);
         end else begin
            exp = sb2.pop_front();
            if (got !== exp) begin
               bad++;
               $display("FAIL sb2_event got kind=%b val=%02h want kind=%b val=%02h",
                        got.kind, got.val, exp.kind, exp.val);
            end
         end
      end
   end

   task automatic drv(input logic e, input logic [7:0] d);
      en = e;
      data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic drv2(input logic e, input logic [7:0] d);
      en2 = e;
      data2 = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({sync1, pos1, rxd1, val1, esot1, esync1} !== 15'h0) begin
         bad++;
         $display("FAIL reset_dut got=%h want=0", {sync1, pos1, rxd1, val1, esot1, esync1});
      end
      total++;
      if ({sync2, pos2, rxd2, val2, esot2, esync2} !== 15'h0) begin
         bad++;
         $display("FAIL reset_dut2 got=%h want=0", {sync2, pos2, rxd2, val2, esot2, esync2});
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      drv(1'b0, 8'h00);
      total++;
      if ({sync1, val1, esync1} !== 3'b000) begin
         bad++;
         $display("FAIL idle_quiet got=%b want=000", {sync1, val1, esync1});
      end
   endtask

   task automatic test_basic();
      drv(1'b1, 8'h00);
      drv(1'b1, 8'h00);
      drv(1'b1, 8'h1D);
      sb1.push_back(ev_sync(1'b0, 3'd0));
      drv(1'b1, 8'hA5);
      total++;
      if ({sync1, esot1, val1, pos1} !== 6'b100_000) begin
         bad++;
         $display("FAIL basic_sync got=%b want=100000", {sync1, esot1, val1, pos1});
      end
      sb1.push_back(ev_data(8'hA5));
      drv(1'b1, 8'h3C);
      total++;
      if ({sync1, val1, rxd1} !== {2'b01, 8'hA5}) begin
         bad++;
         $display("FAIL basic_first got=%b/%02h want=01/a5", {sync1, val1}, rxd1);
      end
      sb1.push_back(ev_data(8'h3C));
      drv(1'b1, 8'h1D);
      sb1.push_back(ev_data(8'h1D));
      drv(1'b1, 8'h1D);
      sb1.push_back(ev_data(8'h1D));
      drv(1'b1, 8'h00);
      total++;
      if ({sync1, val1, rxd1} !== {2'b01, 8'h1D}) begin
         bad++;
         $display("FAIL basic_passthru got=%b/%02h want=01/1d", {sync1, val1}, rxd1);
      end
      drv(1'b0, 8'h00);
      total++;
      if (val1 !== 1'b0) begin
         bad++;
         $display("FAIL basic_drop got=%b want=0", val1);
      end
      total++;
      if (sb1.size() != 0) begin
         bad++;
         $display("FAIL basic_pending got=%0d want=0", sb1.size());
      end
   endtask

   // Stream 00, then 1D and A5 shifted up 3 bits across byte boundaries.
   task automatic test_offset3();
      drv(1'b1, 8'h00);
      drv(1'b1, 8'hE8);
      sb1.push_back(ev_sync(1'b0, 3'd3));
      drv(1'b1, 8'h28);
      total++;
      if ({sync1, esot1, pos1} !== 5'b10_011) begin
         bad++;
         $display("FAIL off3_sync got=%b want=10011", {sync1, esot1, pos1});
      end
      sb1.push_back(ev_data(8'hA5));
      drv(1'b1, 8'h05);
      sb1.push_back(ev_data(8'h00));
      drv(1'b1, 8'h00);
      drv(1'b0, 8'h00);
      total++;
      if (sb1.size() != 0) begin
         bad++;
         $display("FAIL off3_pending got=%0d want=0", sb1.size());
      end
   endtask

   task automatic test_err_tol();
      drv(1'b1, 8'h00);
      drv(1'b1, 8'h1C);
      sb1.push_back(ev_sync(1'b1, 3'd0));
      drv(1'b1, 8'h77);
      total++;
      if ({sync1, esot1, pos1} !== 5'b11_000) begin
         bad++;
         $display("FAIL errtol_sync got=%b want=11000", {sync1, esot1, pos1});
      end
      sb1.push_back(ev_data(8'h77));
      drv(1'b1, 8'h00);
      total++;
      if (esot1 !== 1'b0) begin
         bad++;
         $display("FAIL errtol_pulse got=%b want=0", esot1);
      end
      drv(1'b0, 8'h00);
      total++;
      if (sb1.size() != 0) begin
         bad++;
         $display("FAIL errtol_pending got=%0d want=0", sb1.size());
      end
   endtask

   // 1D cannot overlap itself at offsets 5 and 2; window 0E9D has exact k=7, 1-bit k=0.
   task automatic test_priority();
      drv(1'b1, 8'h00);
      drv(1'b1, 8'h00);
      drv(1'b1, 8'h9D);
      sb1.push_back(ev_sync(1'b0, 3'd7));
      drv(1'b1, 8'h0E);
      total++;
      if ({sync1, esot1, pos1} !== 5'b10_111) begin
         bad++;
         $display("FAIL prio_sync got=%b want=10111", {sync1, esot1, pos1});
      end
      sb1.push_back(ev_data(8'hAA));
      drv(1'b1, 8'h55);
      drv(1'b0, 8'h00);
      total++;
      if (sb1.size() != 0) begin
         bad++;
         $display("FAIL prio_pending got=%0d want=0", sb1.size());
      end
   endtask

   task automatic test_timeout();
      drv2(1'b1, 8'h00);
      drv2(1'b1, 8'h1C);
      for (int i = 0; i < 3; i++) begin
         drv2(1'b1, 8'h77);
         total++;
         if ({sync2, esync2} !== 2'b00) begin
            bad++;
            $display("FAIL tmo_early%0d got=%b want=00", i, {sync2, esync2});
         end
      end
      sb2.push_back(ev_tmo());
      drv2(1'b1, 8'h77);
      total++;
      if ({sync2, esync2} !== 2'b01) begin
         bad++;
         $display("FAIL tmo_pulse got=%b want=01", {sync2, esync2});
      end
      drv2(1'b1, 8'h77);
      total++;
      if (esync2 !== 1'b0) begin
         bad++;
         $display("FAIL tmo_one_cycle got=%b want=0", esync2);
      end
      drv2(1'b1, 8'h00);
      drv2(1'b1, 8'h1D);
      sb2.push_back(ev_sync(1'b0, 3'd0));
      drv2(1'b1, 8'hA5);
      total++;
      if (sync2 !== 1'b1) begin
         bad++;
         $display("FAIL tmo_rehunt got=%b want=1", sync2);
      end
      sb2.push_back(ev_data(8'hA5));
      drv2(1'b1, 8'h00);
      drv2(1'b0, 8'h00);
      total++;
      if (sb2.size() != 0) begin
         bad++;
         $display("FAIL tmo_pending got=%0d want=0", sb2.size());
      end
   endtask

   task automatic test_enable_reset();
      drv(1'b1, 8'h00);
      drv(1'b1, 8'hE8);
      sb1.push_back(ev_sync(1'b0, 3'd3));
      drv(1'b1, 8'h28);
      sb1.push_back(ev_data(8'hA5));
      drv(1'b1, 8'h05);
      drv(1'b0, 8'h00);
      total++;
      if ({val1, sync1, esot1, pos1} !== 6'b000_011) begin
         bad++;
         $display("FAIL en_drop got=%b want=000011", {val1, sync1, esot1, pos1});
      end
      // Enable falls on the very edge where sync would be accepted.
      drv(1'b1, 8'h00);
      drv(1'b1, 8'h00);
      drv(1'b1, 8'h1D);
      drv(1'b0, 8'hA5);
      total++;
      if ({sync1, pos1} !== 4'b0_011) begin
         bad++;
         $display("FAIL en_vs_sync got=%b want=0011", {sync1, pos1});
      end
      drv(1'b1, 8'h00);
      drv(1'b1, 8'h00);
      total++;
      if (pos1 !== 3'd3) begin
         bad++;
         $display("FAIL en_pos_held got=%0d want=3", pos1);
      end
      drv(1'b1, 8'h1D);
      sb1.push_back(ev_sync(1'b0, 3'd0));
      drv(1'b1, 8'hA5);
      sb1.push_back(ev_data(8'hA5));
      drv(1'b1, 8'h3C);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      total++;
      if ({sync1, pos1, rxd1, val1, esot1, esync1} !== 15'h0) begin
         bad++;
         $display("FAIL rst_mid got=%h want=0", {sync1, pos1, rxd1, val1, esot1, esync1});
      end
      data = 8'h77;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drv(1'b1, 8'h77);
         total++;
         if ({val1, sync1, esync1} !== 3'b000) begin
            bad++;
            $display("FAIL rst_residual%0d got=%b want=000", i, {val1, sync1, esync1});
         end
      end
      drv(1'b0, 8'h00);
      total++;
      if (sb1.size() != 0) begin
         bad++;
         $display("FAIL enrst_pending got=%0d want=0", sb1.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_offset3();
      test_err_tol();
      test_priority();
      test_timeout();
      test_enable_reset();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
